// File: rtl/busca_instrucao.sv
// Instruction fetch: assembles a 16-bit word from two byte reads and hands it to the decoder.
// Optional macro BUSCA_ALIGN_CHECK_EN: odd fetch addresses raise erro_alinhamento instead of reading memory.
module busca_instrucao #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] endereco,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic [15:0] instrucao,
    output logic [15:0] instrucao_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_stall
`ifdef BUSCA_ALIGN_CHECK_EN
    ,
    output logic        erro_alinhamento
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BYTE_HI = 2'd1;
    localparam logic [1:0] BYTE_LO = 2'd2;
    localparam logic [1:0] SAIDA   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
`ifdef BUSCA_ALIGN_CHECK_EN
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        instr_d = instr_q;
        pc_d    = pc_q;
`ifdef BUSCA_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    addr_d = endereco;
`ifdef BUSCA_ALIGN_CHECK_EN
                    err_d  = 1'b0;
                    if (endereco[0]) begin
                        // Misaligned: skip memory entirely and present a null word
                        state_d = SAIDA;
                        instr_d = 16'h0000;
                        pc_d    = endereco;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BYTE_HI;
                    end
`else
                    state_d = BYTE_HI;
`endif
                end
            end
            BYTE_HI: begin
                if (mem_ack) begin
                    byte_d  = mem_data;
                    state_d = BYTE_LO;
                end
            end
            BYTE_LO: begin
                if (mem_ack) begin
                    instr_d = (BIG_ENDIAN != 0) ? {byte_q, mem_data} : {mem_data, byte_q};
                    pc_d    = addr_q;
                    state_d = SAIDA;
                end
            end
            SAIDA: begin
                if (instr_ready) begin
                    state_d = IDLE;
`ifdef BUSCA_ALIGN_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect wins over any memory completion or decoder acceptance
        if (flush) begin
            state_d = IDLE;
            addr_d  = addr_q;
            byte_d  = byte_q;
            instr_d = instr_q;
            pc_d    = pc_q;
`ifdef BUSCA_ALIGN_CHECK_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            byte_q  <= 8'h00;
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
`ifdef BUSCA_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
`ifdef BUSCA_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req      = (state_q == BYTE_HI) || (state_q == BYTE_LO);
    assign mem_addr     = (state_q == BYTE_LO) ? addr_q + 16'd1 : addr_q;
    assign instr_valid  = (state_q == SAIDA);
    assign instrucao    = instr_q;
    assign instrucao_pc = pc_q;
    assign pc_stall     = mem_req || ((state_q == SAIDA) && !instr_ready);
`ifdef BUSCA_ALIGN_CHECK_EN
    assign erro_alinhamento = err_q;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: directed fetches against a byte-memory model with configurable ack delay.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    logic        reset, fetch_en, flush, instr_ready;
    logic [15:0] endereco;
    logic [15:0] mem_addr, instrucao, instrucao_pc;
    logic        mem_req, mem_ack, instr_valid, pc_stall;
    logic [7:0]  mem_data;
`ifdef BUSCA_ALIGN_CHECK_EN
    logic        erro_alinhamento;
`endif

    int total = 0;
    int bad   = 0;
    int pushed = 0;
    int hs_cnt = 0;
    int delay  = 0;
    int wcnt   = 0;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] pc;
        logic        err;
    } exp_t;
    exp_t sb[$];

    busca_instrucao #(.BIG_ENDIAN(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .endereco     (endereco),
        .fetch_en     (fetch_en),
        .flush        (flush),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack),
        .instrucao    (instrucao),
        .instrucao_pc (instrucao_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_stall     (pc_stall)
`ifdef BUSCA_ALIGN_CHECK_EN
        ,
        .erro_alinhamento (erro_alinhamento)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0010: mem_byte = 8'h12;
            16'h0011: mem_byte = 8'h34;
            default:  mem_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Memory answers after 'delay' wait cycles per byte
    assign mem_ack  = mem_req && (wcnt >= delay);
    assign mem_data = mem_ack ? mem_byte(mem_addr) : 8'h00;

    always @(posedge clock) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] ins, input logic [15:0] pc, input logic err);
        exp_t e;
        e.ins = ins;
        e.pc  = pc;
        e.err = err;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: inputs settle at negedge, so negedge+1 shows exactly what the next posedge samples
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    always begin
        @(negedge clock);
        #1;
        if (!reset && instr_valid && instr_ready && !flush) begin
            hs_cnt++;
            chk("hs_pc_stall", {31'd0, pc_stall}, 32'd0);
            if (sb.size() == 0) begin
                chk("hs_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hs_instrucao", {16'd0, instrucao}, {16'd0, e.ins});
                chk("hs_pc", {16'd0, instrucao_pc}, {16'd0, e.pc});
`ifdef BUSCA_ALIGN_CHECK_EN
                chk("hs_erro", {31'd0, erro_alinhamento}, {31'd0, e.err});
`endif
            end
        end
        if (!reset && mem_req && prev_req && !prev_ack)
            chk("mem_addr_held", {16'd0, mem_addr}, {16'd0, prev_addr});
        prev_req  = mem_req && !reset;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] held;
        int n;
        reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; instr_ready = 1'b1; endereco = 16'h0000;
        repeat (2) @(negedge clock);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, pc_stall}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst_instr", {16'd0, instrucao}, 32'd0);
        chk("rst_pc",    {16'd0, instrucao_pc}, 32'd0);
        reset = 1'b0;

        // Zero-wait fetch: valid after 3 edges, stall drops only in handshake cycle
        endereco = 16'h0010; fetch_en = 1'b1; push(16'h1234, 16'h0010, 1'b0);
        @(negedge clock); fetch_en = 1'b0;
        chk("t1_hi_req",   {31'd0, mem_req}, 32'd1);
        chk("t1_hi_addr",  {16'd0, mem_addr}, 32'h0010);
        chk("t1_hi_stall", {31'd0, pc_stall}, 32'd1);
        chk("t1_hi_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clock);
        chk("t1_lo_addr",  {16'd0, mem_addr}, 32'h0011);
        chk("t1_lo_stall", {31'd0, pc_stall}, 32'd1);
        @(negedge clock);
        chk("t1_valid",    {31'd0, instr_valid}, 32'd1);
        chk("t1_instr",    {16'd0, instrucao}, 32'h1234);
        chk("t1_hs_stall", {31'd0, pc_stall}, 32'd0);
        @(negedge clock);
        chk("t1_idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_idle_req",   {31'd0, mem_req}, 32'd0);

        // Two wait cycles per byte: valid after 7 edges
        delay = 2;
        endereco = 16'h0010; fetch_en = 1'b1; push(16'h1234, 16'h0010, 1'b0);
        n = 0;
        do begin
            @(negedge clock); fetch_en = 1'b0; n++;
        end while (!instr_valid && n < 20);
        chk("t2_latency", n, 32'd7);
        chk("t2_instr", {16'd0, instrucao}, 32'h1234);
        @(negedge clock);
        delay = 0;

        // Decoder back-pressure for 5 cycles
        instr_ready = 1'b0;
        held = {mem_byte(16'h0100), mem_byte(16'h0101)};
        endereco = 16'h0100; fetch_en = 1'b1; push(held, 16'h0100, 1'b0);
        @(negedge clock); fetch_en = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", {31'd0, instr_valid}, 32'd1);
            chk("t3_stall", {31'd0, pc_stall}, 32'd1);
            chk("t3_instr", {16'd0, instrucao}, {16'd0, held});
            if (i < 4) @(negedge clock);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        chk("t3_done", {31'd0, instr_valid}, 32'd0);

        // Flush in BYTE_LO while memory acks: nothing delivered, output word held
        endereco = 16'h0020; fetch_en = 1'b1;
        @(negedge clock); fetch_en = 1'b0;
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_req",   {31'd0, mem_req}, 32'd0);
        chk("t4_held",  {16'd0, instrucao}, {16'd0, held});
        endereco = 16'h002E; fetch_en = 1'b1;
        push({mem_byte(16'h002E), mem_byte(16'h002F)}, 16'h002E, 1'b0);
        @(negedge clock); fetch_en = 1'b0;
        repeat (3) @(negedge clock);

        // Flush in SAIDA beats instr_ready: no transfer
        endereco = 16'h0040; fetch_en = 1'b1;
        @(negedge clock); fetch_en = 1'b0;
        repeat (2) @(negedge clock);
        chk("t5_saida", {31'd0, instr_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        chk("t5_dropped", {31'd0, instr_valid}, 32'd0);

`ifndef BUSCA_ALIGN_CHECK_EN
        // Address wrap on the second byte
        endereco = 16'hFFFE; fetch_en = 1'b1;
        push({mem_byte(16'hFFFE), mem_byte(16'hFFFF)}, 16'hFFFE, 1'b0);
        @(negedge clock); fetch_en = 1'b0;
        repeat (3) @(negedge clock);
        endereco = 16'hFFFF; fetch_en = 1'b1;
        push({mem_byte(16'hFFFF), mem_byte(16'h0000)}, 16'hFFFF, 1'b0);
        @(negedge clock); fetch_en = 1'b0;
        chk("t6_hi_addr", {16'd0, mem_addr}, 32'hFFFF);
        @(negedge clock);
        chk("t6_lo_addr", {16'd0, mem_addr}, 32'h0000);
        repeat (2) @(negedge clock);
`endif

        // Reset mid BYTE_HI
        delay = 3;
        endereco = 16'h0030; fetch_en = 1'b1;
        @(negedge clock); fetch_en = 1'b0;
        chk("t7_req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; flush = 1'b1;
        @(negedge clock);
        chk("t7_req",   {31'd0, mem_req}, 32'd0);
        chk("t7_addr",  {16'd0, mem_addr}, 32'd0);
        chk("t7_valid", {31'd0, instr_valid}, 32'd0);
        chk("t7_stall", {31'd0, pc_stall}, 32'd0);
        chk("t7_instr", {16'd0, instrucao}, 32'd0);
        chk("t7_pc",    {16'd0, instrucao_pc}, 32'd0);
        reset = 1'b0; flush = 1'b0; delay = 0;

`ifdef BUSCA_ALIGN_CHECK_EN
        endereco = 16'h0007; fetch_en = 1'b1; push(16'h0000, 16'h0007, 1'b1);
        @(negedge clock); fetch_en = 1'b0;
        chk("t8_req",   {31'd0, mem_req}, 32'd0);
        chk("t8_valid", {31'd0, instr_valid}, 32'd1);
        chk("t8_err",   {31'd0, erro_alinhamento}, 32'd1);
        chk("t8_instr", {16'd0, instrucao}, 32'd0);
        @(negedge clock);
        chk("t8_err_clr", {31'd0, erro_alinhamento}, 32'd0);
`endif

        repeat (3) @(negedge clock);
        chk("sb_empty", sb.size(), 32'd0);
        chk("hs_count", hs_cnt, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
